sram_controller: RTL and testbench
==================================

# sram_controller

Sequences every data-memory access of the pipelined ARM core onto a 16-bit external SRAM. Sits between the MEM stage and the SRAM pins. Splits each 32-bit load/store into two half-word phases with a fixed access time. Holds `ready` low so the pipeline freezes until the access completes.

## Interface
- `T_ACC`, default 2: cycles per half-word phase; minimum 2.
- `SRAM_AW`, default 18: SRAM half-word address width.
- `DATA_BASE`, default 1024: byte address mapped to SRAM half-word 0.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  store request from MEM stage.
- `rd_en`  in  1  load request from MEM stage.
- `address`  in  32  byte address; held stable while `ready`=0.
- `write_data`  in  32  store data; held stable while `ready`=0.
- `read_data`  out  32  registered load result.
- `ready`  out  1  0 = freeze pipeline.
- `SRAM_DQ`  inout  16  data bus; driven only in write phases, else high-Z.
- `SRAM_ADDR`  out  SRAM_AW  half-word address.
- `SRAM_WE_N`  out  1  active-low write strobe.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied 0.

## Operation
- States: IDLE, LO, HI, FINISH. Phase counter `cnt` counts 0..T_ACC-1 in LO and HI.
- IDLE: if `wr_en|rd_en`, go to LO with `cnt`=0; latch op type, write priority if both set.
- LO: after T_ACC cycles, go to HI. HI: after T_ACC cycles, go to FINISH. FINISH: always go to IDLE.
- `ready` = (IDLE & ~(wr_en|rd_en)) | FINISH. It is combinational, so a new request in IDLE drops `ready` in the same cycle.
- Address mapping:
  - word = (address − DATA_BASE) >> 2, modulo 2^(SRAM_AW−1); out-of-range addresses wrap silently.
  - LO drives `SRAM_ADDR` = {word, 0]; HI drives {word, 1}. IDLE and FINISH drive 0.
- Write:
  - LO drives `write_data[15:0]` on `SRAM_DQ`; HI drives `write_data[31:16]`.
  - `SRAM_WE_N`=0 on every phase cycle except the last (`cnt`=T_ACC−1), which gives address/data hold.
- Read:
  - `SRAM_WE_N`=1 and DQ is high-Z.
  - `SRAM_DQ` is sampled into `read_data[15:0]` on the last LO cycle and into `read_data[31:16]` on the last HI cycle.
  - `read_data` is valid in FINISH and held until the next read overwrites it.
- Writes never modify `read_data`.

## Timing
- The request is first seen in cycle 0 (IDLE). `ready`=1 in cycle 1+2·T_ACC, i.e. cycle 5 for T_ACC=2, so the pipeline is frozen 5 cycles.
- Back-to-back accesses: FINISH → IDLE, then the new request drops `ready` at once. There is one FINISH-cycle gap between accesses.
- Reset values:
  - state IDLE, `cnt` 0, `read_data` 0.
  - `ready` = ~(wr_en|rd_en).
  - `SRAM_ADDR` 0, `SRAM_WE_N` 1, `SRAM_DQ` high-Z.
- Reset mid-access aborts immediately. `SRAM_WE_N` rises asynchronously and any partial write is not retried.
- Requests dropping while `ready`=0 is illegal. Behaviour continues on the latched op type.

## Configuration
- `SRAM_READ_CACHE_EN` defined:
  - Adds a one-word read cache: valid bit, tag (word index), 32-bit data.
  - Read hit in IDLE goes to FINISH directly, so `ready`=1 in cycle 1 and `read_data` is loaded from the cache on that transition.
  - A read miss fills the cache in FINISH.
  - A write to a matching tag updates the cache data (write-through); the write always goes to SRAM.
  - Reset clears the valid bit.
- `SRAM_READ_CACHE_EN` undefined: no cache logic; every read takes the full 1+2·T_ACC cycles.

## Structure
- Shared package/include `sram_pkg`:
  - state encoding (IDLE=0, LO=1, HI=2, FINISH=3);
  - `DATA_BASE` default;
  - half-word select constants.
- Sub-module `sram_read_cache` (tag/data/valid registers, hit compare) is instantiated only under `SRAM_READ_CACHE_EN`. The FSM and counter stay in `sram_controller`.

## Test plan
- Store: address 1024, data 0xDEADBEEF, T_ACC=2.
  - Expect half-word 0 = 0xBEEF and half-word 1 = 0xDEAD.
  - Expect `SRAM_WE_N` low on cycles 1 and 3 only, and `ready`=1 in cycle 5.
- Load: from 1028, model holding 0x1234 at 2 and 0xABCD at 3.
  - Expect `read_data`=0xABCD1234 valid with `ready`=1 in cycle 5.
- Back-to-back: store at 1032 then load at 1032.
  - Expect the load to return the stored word and `ready` high in exactly one cycle between the two freezes.
- Reset: assert `rst_n`=0 in cycle 2 of a store.
  - Expect `SRAM_WE_N`=1 and DQ high-Z asynchronously, state IDLE, and `read_data`=0.
- Simultaneous `rd_en`=`wr_en`=1 at 1024: expect a write sequence and `read_data` unchanged.
- With `SRAM_READ_CACHE_EN`: load 1028 twice.
  - Expect the second load to give `ready`=1 in cycle 1 with the same data.
  - Then store 0x0 to 1028 and load again: expect 0x00000000 as a cache hit.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the 16-bit external SRAM controller: FSM encoding,
// default data-segment base and half-word select constants.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LO     = 2'd1,
    HI     = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int unsigned DATA_BASE_DEF = 1024;

  localparam logic HW_LO = 1'b0;
  localparam logic HW_HI = 1'b1;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: request, address/data and the
// ready (pipeline freeze) handshake.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_read_cache.sv
// One-word read cache: valid bit, word-index tag and 32-bit data with a
// combinational hit compare. Filled after a read miss, updated by matching writes.
module sram_read_cache #(
  parameter int unsigned TAG_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             fill_en,
  input  logic             wt_en,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [31:0]      upd_data,
  output logic             hit,
  output logic [31:0]      hit_data
);

  logic             vld_q, vld_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (fill_en) begin
      vld_d  = 1'b1;
      tag_d  = upd_tag;
      data_d = upd_data;
    end else if (wt_en && vld_q && (tag_q == upd_tag)) begin
      data_d = upd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= vld_d;
  end

  // Tag/data are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign hit      = vld_q && (tag_q == lookup_tag);
  assign hit_data = data_q;

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two timed half-word SRAM phases,
// holding ready low meanwhile. Define SRAM_READ_CACHE_EN to add a one-word read cache.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned T_ACC     = 2,
  parameter int unsigned SRAM_AW   = 18,
  parameter int unsigned DATA_BASE = DATA_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_controller_if.slave   mem,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int unsigned CNT_W = $clog2(T_ACC);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               req, last, cache_hit, dq_oe;
  logic [15:0]        dq_out;
  logic [SRAM_AW-2:0] word;

  assign req  = mem.wr_en | mem.rd_en;
  assign last = (cnt_q == CNT_W'(T_ACC - 1));
  // Out-of-range addresses wrap silently into the SRAM word space.
  assign word = (SRAM_AW-1)'((mem.address - 32'(DATA_BASE)) >> 2);

`ifdef SRAM_READ_CACHE_EN
  logic        cache_tag_hit;
  logic [31:0] cache_rdata;

  sram_read_cache #(.TAG_W(SRAM_AW-1)) u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (word),
    .fill_en    ((state_q == FINISH) && !is_wr_q),
    .wt_en      ((state_q == FINISH) && is_wr_q),
    .upd_tag    (word),
    .upd_data   (is_wr_q ? mem.write_data : rdata_q),
    .hit        (cache_tag_hit),
    .hit_data   (cache_rdata)
  );

  assign cache_hit = cache_tag_hit & mem.rd_en & ~mem.wr_en;
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    case (state_q)
      IDLE: if (req) begin
        is_wr_d = mem.wr_en;
        cnt_d   = '0;
        state_d = cache_hit ? FINISH : LO;
      end
      LO: begin
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        if (last) state_d = HI;
      end
      HI: begin
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        if (last) state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Each half of a load is captured on the last cycle of its phase.
  always_comb begin
    rdata_d = rdata_q;
    if (!is_wr_q && last) begin
      if (state_q == LO)      rdata_d[15:0]  = SRAM_DQ;
      else if (state_q == HI) rdata_d[31:16] = SRAM_DQ;
    end
`ifdef SRAM_READ_CACHE_EN
    if ((state_q == IDLE) && cache_hit) rdata_d = cache_rdata;
`endif
  end

  always_comb begin
    mem.ready = 1'b0;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = mem.write_data[15:0];
    case (state_q)
      IDLE:   mem.ready = ~req;
      LO: begin
        SRAM_ADDR = {word, HW_LO};
        SRAM_WE_N = ~(is_wr_q & ~last);
        dq_oe     = is_wr_q;
      end
      HI: begin
        SRAM_ADDR = {word, HW_HI};
        SRAM_WE_N = ~(is_wr_q & ~last);
        dq_oe     = is_wr_q;
        dq_out    = mem.write_data[31:16];
      end
      default: mem.ready = 1'b1;
    endcase
  end

  assign SRAM_DQ       = dq_oe ? dq_out : 16'hzzzz;
  assign mem.read_data = rdata_q;
  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign SRAM_CE_N     = 1'b0;
  assign SRAM_OE_N     = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: table of load/store vectors with a read-data
// scoreboard, a half-word SRAM model, plus reset and cache sequences.
module tb_sram_controller;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_controller_if bus();
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  logic        model_oe, pat_en, pl_en;
  logic [7:0]  pl_idx;
  logic [15:0] pl_val, model_q;
  logic [15:0] mem_arr [256];

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] sb_q [$];

  sram_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n)
  );

  always_comb model_q = pat_en ? 16'h5A5A : mem_arr[sram_addr[7:0]];
  assign sram_dq = model_oe ? model_q : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) mem_arr[sram_addr[7:0]] <= sram_dq;
    else if (pl_en) mem_arr[pl_idx] <= pl_val;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s.%s: got 0x%0h required 0x%0h", tag, what, got, exp);
    end else begin
      passes++;
    end
  endtask

  function automatic logic [17:0] hw_addr(input logic [31:0] a, input logic hi);
    return {17'((a - 32'd1024) >> 2), hi};
  endfunction

  task automatic preload(input logic [7:0] idx, input logic [15:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk); #1;
    pl_en  = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit from_finish);
    int          cyc;
    logic [4:0]  we_mask;
    logic [17:0] a_lo, a_hi, e_lo, e_hi;
    logic [31:0] exp_rd;
    if (from_finish) begin
      @(posedge clk); #1;
    end
    bus.wr_en      = v.wr;
    bus.rd_en      = v.rd;
    bus.address    = v.addr;
    bus.write_data = v.wdata;
    model_oe       = v.rd & ~v.wr;
    sb_q.push_back(v.exp_rd);
    #1;
    check(tag, "ready_c0", 32'(bus.ready), 32'd0);
    we_mask    = '0;
    we_mask[0] = ~sram_we_n;
    a_lo = '0;
    a_hi = '0;
    cyc  = 0;
    while (!bus.ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < 5) we_mask[cyc] = ~sram_we_n;
      if (cyc == 1) a_lo = sram_addr;
      if (cyc == 3) a_hi = sram_addr;
    end
    check(tag, "cycles_to_ready", 32'(cyc), 32'(v.exp_cyc));
    exp_rd = sb_q.pop_front();
    check(tag, "read_data", bus.read_data, exp_rd);
    if (v.exp_cyc > 1) begin
      e_lo = hw_addr(v.addr, 1'b0);
      e_hi = hw_addr(v.addr, 1'b1);
      check(tag, "we_n_low_cycles", 32'(we_mask), v.wr ? 32'h0A : 32'h0);
      check(tag, "addr_lo", 32'(a_lo), 32'(e_lo));
      check(tag, "addr_hi", 32'(a_hi), 32'(e_hi));
      if (v.wr) begin
        check(tag, "sram_hw_lo", 32'(mem_arr[e_lo[7:0]]), 32'(v.wdata[15:0]));
        check(tag, "sram_hw_hi", 32'(mem_arr[e_hi[7:0]]), 32'(v.wdata[31:16]));
      end
    end
  endtask

  vec_t vecs [7];
  vec_t v1;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd1024,            32'hDEADBEEF, 32'h00000000, 5};
    vecs[1] = '{1'b0, 1'b1, 32'd1028,            32'h0,        32'hABCD1234, 5};
    vecs[2] = '{1'b1, 1'b0, 32'd1032,            32'hCAFEF00D, 32'hABCD1234, 5};
    vecs[3] = '{1'b0, 1'b1, 32'd1032,            32'h0,        32'hCAFEF00D, 5};
    vecs[4] = '{1'b1, 1'b1, 32'd1024,            32'h11223344, 32'hCAFEF00D, 5};
    vecs[5] = '{1'b1, 1'b0, 32'd1024 + (1 << 19), 32'h55667788, 32'hCAFEF00D, 5};
    vecs[6] = '{1'b0, 1'b1, 32'd1020,            32'h0,        32'hF0F00F0F, 5};

    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    model_oe = 1'b0;
    pat_en = 1'b0;
    pl_en = 1'b0;
    pl_idx = '0;
    pl_val = '0;
    #2;
    check("reset", "ready", 32'(bus.ready), 32'd1);
    check("reset", "we_n", 32'(sram_we_n), 32'd1);
    check("reset", "addr", 32'(sram_addr), 32'd0);
    check("reset", "read_data", bus.read_data, 32'd0);
    check("reset", "tied_pins", 32'({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}), 32'd0);
    bus.rd_en = 1'b1;
    #1;
    check("reset", "ready_with_req", 32'(bus.ready), 32'd0);
    bus.rd_en = 1'b0;

    preload(8'd2,   16'h1234);
    preload(8'd3,   16'hABCD);
    preload(8'hFE,  16'h0F0F);
    preload(8'hFF,  16'hF0F0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], i != 0);

    // Reset two cycles into a store: bus must release at once, nothing retried.
    @(posedge clk); #1;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;
    bus.address = 32'd1024;
    bus.write_data = 32'hA5A5A5A5;
    model_oe = 1'b0;
    @(posedge clk); #1;
    check("rst_mid", "we_n_c1", 32'(sram_we_n), 32'd0);
    @(posedge clk); #1;
    check("rst_mid", "dq_driven_c2", 32'(sram_dq), 32'h0000A5A5);
    rst_n = 1'b0;
    model_oe = 1'b1;
    pat_en = 1'b1;
    #2;
    check("rst_mid", "we_n", 32'(sram_we_n), 32'd1);
    check("rst_mid", "dq_released", 32'(sram_dq), 32'h00005A5A);
    check("rst_mid", "read_data", bus.read_data, 32'd0);
    check("rst_mid", "addr", 32'(sram_addr), 32'd0);
    check("rst_mid", "ready_req", 32'(bus.ready), 32'd0);
    bus.wr_en = 1'b0;
    #1;
    check("rst_mid", "ready_idle", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_oe = 1'b0;
    pat_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid", "idle_ready", 32'(bus.ready), 32'd1);
    check("rst_mid", "idle_we_n", 32'(sram_we_n), 32'd1);
    check("rst_mid", "idle_addr", 32'(sram_addr), 32'd0);
    check("rst_mid", "hw_hi_untouched", 32'(mem_arr[1]), 32'h00005566);

    v1 = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'hABCD1234, 5};
    run_vec("recover_load", v1, 1'b0);

`ifdef SRAM_READ_CACHE_EN
    v1 = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'hABCD1234, 1};
    run_vec("cache_hit", v1, 1'b1);
    v1 = '{1'b1, 1'b0, 32'd1028, 32'h0, 32'hABCD1234, 5};
    run_vec("cache_wt_store", v1, 1'b1);
    v1 = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'h00000000, 1};
    run_vec("cache_hit_after_wt", v1, 1'b1);
`endif

    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
